// File: rtl/dncnt_rld.sv
// Parametrised down counter with parallel load, a reload register and
// selectable wrap/reload on underflow. The combinational borrow-out (co)
// lets several instances be chained into a wider counter, and the
// registered terminal-count pulse (tc) feeds interrupt/event logic.
module dncnt_rld #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             res,
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    input  logic             rld_wr,
    input  logic             ci,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Next-state for counter, reload register and terminal-count pulse.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        rld_d = rld_q;
        tc_d  = 1'b0;
        if (clk) begin
            // The reload register takes d independently of load/count; an
            // underflow in the same cycle still sees the old rld_q.
            if (rld_wr) begin
                rld_d = d;
            end
            if (ld) begin
                cnt_d = d;
            end else if (ci) begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else begin
                    tc_d  = 1'b1;
                    cnt_d = mode ? rld_q : '1;
                end
            end
        end
    end

    // State registers with synchronous, top-priority reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample together.
        if (res) begin
            cnt_q <= '0;
            rld_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
            tc_q  <= tc_d;
        end
    end

    // Borrow-out is purely combinational so a chained upper stage sees it
    // in the same cycle, regardless of clk or ld.
    assign co = ci & cnt_zero;
    assign q  = cnt_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_dncnt_rld.sv
// Self-checking bench for dncnt_rld: an 8-bit instance, a 1-bit instance
// compared against the classic bit-slice equation, and two 4-bit
// instances cascaded through co->ci compared against an 8-bit down count.
module tb_dncnt_rld;

    logic       sys_clk;
    logic       res;
    logic       clk;
    logic [7:0] d;
    logic       ld;
    logic       rld_wr;
    logic       ci;
    logic       mode;
    logic [7:0] q;
    logic       co;
    logic       tc;

    logic       w1_q, w1_co, w1_tc;

    logic       casc_ci;
    logic [3:0] lo_q, hi_q;
    logic       lo_co, hi_co, lo_tc, hi_tc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic       w1_q;
        logic       w1_tc;
        logic [7:0] casc;
    } exp_t;

    exp_t exp_queue[$];

    // Bench-side reference state.
    logic [7:0] m_q, m_rld;
    logic       m_tc;
    logic       m_w1;
    logic [7:0] m_casc;
    bit         known;

    dncnt_rld #(.WIDTH(8)) u_dut (
        .sys_clk(sys_clk), .res(res), .clk(clk), .d(d), .ld(ld),
        .rld_wr(rld_wr), .ci(ci), .mode(mode), .q(q), .co(co), .tc(tc)
    );

    dncnt_rld #(.WIDTH(1)) u_w1 (
        .sys_clk(sys_clk), .res(res), .clk(clk), .d(d[0]), .ld(ld),
        .rld_wr(rld_wr), .ci(ci), .mode(1'b0), .q(w1_q), .co(w1_co), .tc(w1_tc)
    );

    dncnt_rld #(.WIDTH(4)) u_lo (
        .sys_clk(sys_clk), .res(res), .clk(1'b1), .d(4'h0), .ld(1'b0),
        .rld_wr(1'b0), .ci(casc_ci), .mode(1'b0), .q(lo_q), .co(lo_co), .tc(lo_tc)
    );

    dncnt_rld #(.WIDTH(4)) u_hi (
        .sys_clk(sys_clk), .res(res), .clk(1'b1), .d(4'h0), .ld(1'b0),
        .rld_wr(1'b0), .ci(lo_co), .mode(1'b0), .q(hi_q), .co(hi_co), .tc(hi_tc)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational borrows, push
    // the expected post-edge state, then pop and compare after the edge.
    task automatic step(input logic r, input logic c, input logic l, input logic rw,
                        input logic cin, input logic md, input logic [7:0] dv);
        exp_t e;
        exp_t got;
        logic [7:0] nq;
        logic       ntc;
        res = r; clk = c; ld = l; rld_wr = rw; ci = cin; mode = md; d = dv;
        #1;
        if (known) begin
            check("co", co, cin && (m_q == 8'd0));
            check("w1_co", w1_co, cin && !m_w1);
            check("casc_co", hi_co, casc_ci && (m_casc == 8'd0));
        end

        // Reference next state.
        nq  = m_q;
        ntc = 1'b0;
        if (r) begin
            nq = 8'd0; m_rld = 8'd0;
            m_w1 = 1'b0;
            e.w1_tc = 1'b0;
        end else begin
            e.w1_tc = c && !l && cin && !m_w1;
            if (c) begin
                if (l) begin
                    nq = dv;
                end else if (cin) begin
                    ntc = (m_q == 8'd0);
                    if (ntc && md) nq = m_rld;
                    else           nq = 8'((int'(m_q) + 255) % 256);
                end
                if (rw) m_rld = dv;
                m_w1 = l ? dv[0] : (m_w1 ^ cin);
            end
        end
        m_q  = nq;
        m_tc = ntc;
        if (r)            m_casc = 8'd0;
        else if (casc_ci) m_casc = m_casc - 8'd1;

        e.q = m_q; e.tc = m_tc; e.w1_q = m_w1; e.casc = m_casc;
        exp_queue.push_back(e);

        @(posedge sys_clk);
        #1;
        got = exp_queue.pop_front();
        check("q", q, got.q);
        check("tc", tc, got.tc);
        check("w1_q", w1_q, got.w1_q);
        check("w1_tc", w1_tc, got.w1_tc);
        check("casc_q", {hi_q, lo_q}, got.casc);
        known = 1'b1;
    endtask

    initial begin
        known = 1'b0;
        m_q = '0; m_rld = '0; m_tc = 1'b0; m_w1 = 1'b0; m_casc = '0;
        res = 1'b1; clk = 1'b0; ld = 1'b0; rld_wr = 1'b0; ci = 1'b0;
        mode = 1'b0; d = '0; casc_ci = 1'b0;
        @(posedge sys_clk);
        #1;

        // Reset for two cycles while a load is requested.
        step(1, 1, 1, 0, 0, 0, 8'h55);
        step(1, 1, 1, 0, 0, 0, 8'h55);

        // Underflow from 0 in wrap mode, then idle.
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 0, 0, 8'h00);

        // Reload register is 0 after reset: mode 1 keeps q at 0, tc each cycle.
        step(0, 1, 1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 1, 1, 8'h00);
        step(0, 1, 0, 0, 1, 1, 8'h00);

        // Load 3, count 5 in wrap mode.
        step(0, 1, 1, 0, 0, 0, 8'h03);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 0, 8'h00);

        // rld=2, auto-reload mode, period of 3.
        step(0, 1, 0, 1, 0, 1, 8'h02);
        step(0, 1, 1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1, 1, 8'h00);

        // Load wins over count at q=0.
        step(0, 1, 1, 0, 0, 0, 8'h00);
        step(0, 1, 1, 0, 1, 0, 8'h77);

        // Reload write coinciding with underflow: q takes old rld (2).
        step(0, 1, 1, 0, 0, 1, 8'h00);
        step(0, 1, 0, 1, 1, 1, 8'h09);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 1, 8'h00);

        // Clock strobe toggling with ci held.
        step(0, 1, 1, 0, 0, 0, 8'h02);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 1, 0, 8'h00);

        // Reset in the middle of a count.
        step(0, 1, 1, 0, 0, 0, 8'h40);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(1, 1, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 1, 0, 8'h00);

        // Cascade of two 4-bit stages from 0, 40 events.
        step(1, 1, 0, 0, 0, 0, 8'h00);
        casc_ci = 1'b1;
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 0, 8'h00);
        casc_ci = 1'b0;

        // Random mix across all controls.
        for (int i = 0; i < 200; i++) begin
            casc_ci = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
